// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared defaults, state type and sizing helpers for the SRAM controller
package sram_controller_pkg;

    localparam int SRAM_ADDR_BITS          = 20;
    localparam int SRAM_DATA_BITS          = 16;
    localparam int SRAM_WRITE_PULSE_CYCLES = 1;
    localparam int SRAM_READ_WAIT_CYCLES   = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_SETUP  = 3'd1,
        ST_WR_PULSE  = 3'd2,
        ST_WR_HOLD   = 3'd3,
        ST_RD_ACTIVE = 3'd4
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves both the we_n pulse and the read wait, so size it for the longer one.
    function automatic int wait_cnt_bits(input int write_pulse, input int read_wait);
        return $clog2(max2(write_pulse, read_wait + 1)) + 1;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - request/response bundle between the SRAM tester and the controller
interface sram_controller_if #(
    parameter int ADDR_BITS = sram_controller_pkg::SRAM_ADDR_BITS,
    parameter int DATA_BITS = sram_controller_pkg::SRAM_DATA_BITS
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic                 write_enable;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data_write;
    logic                 rd_valid;
    logic [DATA_BITS-1:0] data_read;

    modport master (
        output req_valid, write_enable, addr, data_write,
        input  req_ready, rd_valid, data_read
    );

    modport slave (
        input  req_valid, write_enable, addr, data_write,
        output req_ready, rd_valid, data_read
    );

endinterface

// File: rtl/sram_data_io.sv
// rtl/sram_data_io.sv - tri-state data pad wrapper; an SB_IO bank replaces the assigns on iCE40
module sram_data_io #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] out_data,
    input  logic             out_en,
    output logic [WIDTH-1:0] in_data,
    inout  wire  [WIDTH-1:0] pad
);

    assign pad     = out_en ? out_data : {WIDTH{1'bz}};
    assign in_data = pad;

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - turns single-word read/write requests into registered async-SRAM pin cycles
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int ADDR_BITS          = SRAM_ADDR_BITS,
    parameter int DATA_BITS          = SRAM_DATA_BITS,
    parameter int WRITE_PULSE_CYCLES = SRAM_WRITE_PULSE_CYCLES,
    parameter int READ_WAIT_CYCLES   = SRAM_READ_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_controller_if.slave     req,
    output logic [ADDR_BITS-1:0] addr_bus,
    inout  wire  [DATA_BITS-1:0] data_bus,
    output logic                 we_n,
    output logic                 oe_n,
    output logic                 ce_n
);

    localparam int CNT_BITS = wait_cnt_bits(WRITE_PULSE_CYCLES, READ_WAIT_CYCLES);
    localparam logic [CNT_BITS-1:0] PULSE_LOAD = CNT_BITS'(WRITE_PULSE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] READ_LOAD  = CNT_BITS'(READ_WAIT_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);

    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic [DATA_BITS-1:0] bus_in;
    logic                 rd_valid_q, rd_valid_d;
    logic                 we_n_q, we_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 ce_n_q, ce_n_d;
    logic                 drive_q, drive_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            ce_n_q     <= 1'b1;
            drive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            ce_n_q     <= ce_n_d;
            drive_q    <= drive_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    addr_d  = req.addr;
                    wdata_d = req.data_write;
                    if (req.write_enable) begin
                        state_d = ST_WR_SETUP;
                    end else begin
                        state_d = ST_RD_ACTIVE;
                        cnt_d   = READ_LOAD;
                    end
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = PULSE_LOAD;
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
            end
            ST_RD_ACTIVE: begin
                // Sample on the edge that closes the last active cycle, while oe_n is still low.
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    rdata_d    = bus_in;
                    rd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pins are decoded from the next state so every strobe leaves a flop.
        we_n_d  = (state_d != ST_WR_PULSE);
        oe_n_d  = (state_d != ST_RD_ACTIVE);
        ce_n_d  = (state_d == ST_IDLE);
        drive_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) || (state_d == ST_WR_HOLD);
    end

    sram_data_io #(
        .WIDTH (DATA_BITS)
    ) u_data_io (
        .out_data (wdata_q),
        .out_en   (drive_q),
        .in_data  (bus_in),
        .pad      (data_bus)
    );

    assign req.req_ready = (state_q == ST_IDLE);
    assign req.rd_valid  = rd_valid_q;
    assign req.data_read = rdata_q;
    assign addr_bus      = addr_q;
    assign we_n          = we_n_q;
    assign oe_n          = oe_n_q;
    assign ce_n          = ce_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller with SRAM pin models
module tb_sram_controller;

    localparam int AB  = 20;
    localparam int DB  = 16;
    localparam int WP1 = 1;
    localparam int RW1 = 1;
    localparam int WP2 = 3;
    localparam int RW2 = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_controller_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) if1 ();
    sram_controller_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) if2 ();

    tri0  [DB-1:0] dbus1;
    tri0  [DB-1:0] dbus2;
    logic [AB-1:0] abus1, abus2;
    logic          we1, oe1, ce1, we2, oe2, ce2;

    sram_controller #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .WRITE_PULSE_CYCLES(WP1), .READ_WAIT_CYCLES(RW1)
    ) dut1 (
        .clk(clk), .reset(reset), .req(if1), .addr_bus(abus1), .data_bus(dbus1),
        .we_n(we1), .oe_n(oe1), .ce_n(ce1)
    );

    sram_controller #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .WRITE_PULSE_CYCLES(WP2), .READ_WAIT_CYCLES(RW2)
    ) dut2 (
        .clk(clk), .reset(reset), .req(if2), .addr_bus(abus2), .data_bus(dbus2),
        .we_n(we2), .oe_n(oe2), .ce_n(ce2)
    );

    // Async SRAM models: drive while selected for read, store on the rising edge of we_n.
    logic [DB-1:0] mem1 [0:(1<<AB)-1];
    logic [DB-1:0] mem2 [0:(1<<AB)-1];
    assign dbus1 = (!ce1 && !oe1 && we1) ? mem1[abus1] : {DB{1'bz}};
    assign dbus2 = (!ce2 && !oe2 && we2) ? mem2[abus2] : {DB{1'bz}};
    always @(posedge we1) if (!ce1) mem1[abus1] <= dbus1;
    always @(posedge we2) if (!ce2) mem2[abus2] <= dbus2;

    logic          sel;
    logic          t_valid, t_we;
    logic [AB-1:0] t_addr;
    logic [DB-1:0] t_data;

    assign if1.req_valid    = t_valid & ~sel;
    assign if2.req_valid    = t_valid & sel;
    assign if1.write_enable = t_we;
    assign if2.write_enable = t_we;
    assign if1.addr         = t_addr;
    assign if2.addr         = t_addr;
    assign if1.data_write   = t_data;
    assign if2.data_write   = t_data;

    logic          s_ready, s_rdv, s_we, s_oe, s_ce;
    logic [DB-1:0] s_rdata, s_dbus;
    logic [AB-1:0] s_abus;
    assign s_ready = sel ? if2.req_ready : if1.req_ready;
    assign s_rdv   = sel ? if2.rd_valid  : if1.rd_valid;
    assign s_rdata = sel ? if2.data_read : if1.data_read;
    assign s_we    = sel ? we2 : we1;
    assign s_oe    = sel ? oe2 : oe1;
    assign s_ce    = sel ? ce2 : ce1;
    assign s_dbus  = sel ? dbus2 : dbus1;
    assign s_abus  = sel ? abus2 : abus1;

    int            checks = 0;
    int            errors = 0;
    logic [DB-1:0] ref_mem [int];
    logic [DB-1:0] last_rd [2];

    function automatic int key(input logic s, input logic [AB-1:0] a);
        return {11'b0, s, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(s_ready), 32'(1));
    endtask

    task automatic do_write(input logic [AB-1:0] a, input logic [DB-1:0] d);
        int wp, busy, ce_lo, we_lo, oe_lo, first_we;
        wp = sel ? WP2 : WP1;
        busy = 0; ce_lo = 0; we_lo = 0; oe_lo = 0; first_we = -1;
        wait_ready();
        t_valid = 1'b1; t_we = 1'b1; t_addr = a; t_data = d;
        tick();
        // Keep presenting junk while busy; it must not disturb the write in flight.
        t_we = 1'($urandom); t_addr = AB'($urandom); t_data = DB'($urandom);
        while (s_ready !== 1'b1 && busy < 20) begin
            busy++;
            if (!s_ce) ce_lo++;
            if (!s_oe) oe_lo++;
            if (!s_we) begin
                we_lo++;
                if (first_we < 0) first_we = busy;
                chk("wr_addr_stable", 32'(s_abus), 32'(a));
                chk("wr_data_stable", 32'(s_dbus), 32'(d));
            end
            tick();
        end
        t_valid = 1'b0;
        chk("wr_busy_cycles", 32'(busy), 32'(wp + 2));
        chk("wr_ce_low", 32'(ce_lo), 32'(wp + 2));
        chk("wr_we_low", 32'(we_lo), 32'(wp));
        chk("wr_we_first", 32'(first_we), 32'(2));
        chk("wr_oe_low", 32'(oe_lo), 32'(0));
        ref_mem[key(sel, a)] = d;
    endtask

    task automatic do_read(input logic [AB-1:0] a);
        int rw, k, lo;
        logic [DB-1:0] exp;
        rw = sel ? RW2 : RW1;
        exp = ref_mem[key(sel, a)];
        lo = 0;
        wait_ready();
        t_valid = 1'b1; t_we = 1'b0; t_addr = a; t_data = DB'($urandom);
        tick();
        t_we = 1'($urandom); t_addr = AB'($urandom);
        k = 1;
        while (s_rdv !== 1'b1 && k < 20) begin
            if (!s_oe && !s_ce) lo++;
            chk("rd_hold_prev", 32'(s_rdata), 32'(last_rd[sel]));
            tick();
            k++;
        end
        t_valid = 1'b0;
        chk("rd_valid_latency", 32'(k), 32'(2 + rw));
        chk("rd_active_cycles", 32'(lo), 32'(1 + rw));
        chk("rd_data", 32'(s_rdata), 32'(exp));
        chk("rd_idle_oe", 32'({s_oe, s_ce, s_ready}), 32'(3'b111));
        tick();
        chk("rd_valid_pulse", 32'(s_rdv), 32'(0));
        chk("rd_data_hold", 32'(s_rdata), 32'(exp));
        last_rd[sel] = exp;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, idx, cyc, start, last_rdv_cyc;
        logic [DB-1:0] expq[$];
        logic [AB-1:0] written[$];
        logic [AB-1:0] ra;
        logic [DB-1:0] rd16;

        sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_addr = '0; t_data = '0;
        last_rd[0] = '0; last_rd[1] = '0;

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_strobes", 32'({we1, oe1, ce1}), 32'(3'b111));
        chk("rst_bus_z", 32'(dbus1), 32'(0));
        chk("rst_addr_bus", 32'(abus1), 32'(0));
        chk("rst_rd_valid", 32'(if1.rd_valid), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(if1.req_ready), 32'(1));
        chk("rst_data_read", 32'(if1.data_read), 32'(0));

        do_write(20'h00012, 16'hA5C3);
        chk("sram_stored", 32'(mem1[20'h00012]), 32'h0000A5C3);
        do_read(20'h00012);

        // Read followed by a write accepted in the rd_valid cycle.
        wait_ready();
        t_valid = 1'b1; t_we = 1'b0; t_addr = 20'h00012;
        tick();
        k = 1;
        while (s_rdv !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("ta_rd_valid", 32'(s_rdv), 32'(1));
        chk("ta_oe_gap", 32'(s_oe), 32'(1));
        chk("ta_bus_gap", 32'(s_dbus), 32'(0));
        chk("ta_rdata", 32'(s_rdata), 32'h0000A5C3);
        t_we = 1'b1; t_addr = 20'hFFFFF; t_data = 16'hFFFF;
        tick();
        t_valid = 1'b0;
        chk("ta_wr_drive", 32'(s_dbus), 32'h0000FFFF);
        chk("ta_wr_strobes", 32'({s_oe, s_we, s_ce}), 32'(3'b110));
        ref_mem[key(1'b0, 20'hFFFFF)] = 16'hFFFF;
        last_rd[0] = 16'hA5C3;
        wait_ready();
        do_read(20'hFFFFF);

        // Streamed alternating write/read with req_valid held high throughout.
        idx = 0; cyc = 0; start = -1; last_rdv_cyc = -1;
        wait_ready();
        t_valid = 1'b1;
        while ((idx < 32 || expq.size() > 0 || s_ready !== 1'b1) && cyc < 2000) begin
            if (s_rdv === 1'b1) begin
                if (expq.size() > 0) chk("stream_rd", 32'(s_rdata), 32'(expq.pop_front()));
                else chk("stream_extra_rd_valid", 32'(s_rdv), 32'(0));
                last_rdv_cyc = cyc;
            end
            if (s_ready === 1'b1 && idx < 32) begin
                if (start < 0) start = cyc;
                t_addr = AB'(idx >> 1);
                t_we   = ((idx % 2) == 0);
                t_data = DB'(idx >> 1) ^ 16'h5555;
                if ((idx % 2) == 1) expq.push_back(DB'(idx >> 1) ^ 16'h5555);
                idx++;
            end else if (s_ready === 1'b1) begin
                t_valid = 1'b0;
            end else begin
                t_we = 1'($urandom); t_addr = AB'($urandom); t_data = DB'($urandom);
            end
            tick();
            cyc++;
        end
        t_valid = 1'b0;
        chk("stream_done", 32'(expq.size()), 32'(0));
        chk("stream_cycles", 32'(last_rdv_cyc - start), 32'(16 * (WP1 + 3) + 16 * (RW1 + 2)));
        for (int i = 0; i < 16; i++) ref_mem[key(1'b0, AB'(i))] = DB'(i) ^ 16'h5555;
        last_rd[0] = 16'd15 ^ 16'h5555;

        for (int i = 0; i < 24; i++) begin
            if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
                ra = 20'h00100 + AB'($urandom_range(0, 63));
                rd16 = DB'($urandom);
                do_write(ra, rd16);
                written.push_back(ra);
            end else begin
                do_read(written[$urandom_range(0, written.size() - 1)]);
            end
        end

        // Reset in the middle of a write pulse.
        wait_ready();
        t_valid = 1'b1; t_we = 1'b1; t_addr = 20'h00300; t_data = 16'h1234;
        tick();
        t_valid = 1'b0;
        chk("ab_setup", 32'({s_ce, s_we}), 32'(2'b01));
        tick();
        chk("ab_pulse_we", 32'(s_we), 32'(0));
        chk("ab_pulse_bus", 32'(s_dbus), 32'h00001234);
        #2 reset = 1'b1;
        #1;
        chk("ab_strobes", 32'({s_we, s_oe, s_ce}), 32'(3'b111));
        chk("ab_bus_z", 32'(s_dbus), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("ab_rd_valid", 32'(s_rdv), 32'(0));
        chk("ab_ready", 32'(s_ready), 32'(1));
        chk("ab_data_read", 32'(s_rdata), 32'(0));
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Second build: longer write pulse, no read wait.
        sel = 1'b1;
        tick();
        do_write(20'h00003, DB'($urandom));
        do_write(20'h00007, DB'($urandom));
        do_read(20'h00003);
        do_read(20'h00007);
        do_write(20'h00003, DB'($urandom));
        do_read(20'h00003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
